// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC control, instruction-memory read port and decode-side handshake.
// master = fetch stage, slave = PC / memory / decode environment.
interface instr_fetch_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic [AW-1:0] pc_in;
  logic [1:0]    pc_ps;
  logic          br_take;
  logic          br_rel;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_data;
  logic [DW-1:0] ir_out;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready;

  modport master (
    input  pc_in, br_take, br_rel, imem_ack, imem_data, ir_ready,
    output pc_ps, imem_req, imem_addr, ir_out, ir_pc, ir_valid
  );

  modport slave (
    output pc_in, br_take, br_rel, imem_ack, imem_data, ir_ready,
    input  pc_ps, imem_req, imem_addr, ir_out, ir_pc, ir_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word reads at the current PC, buffers returned words for
// decode and drives the PC select. Define PREFETCH_BUF_EN for a 2-entry buffer (default 1).
module instr_fetch #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input logic           clock,
  input logic           reset,
  instr_fetch_if.master bus
);

`ifdef PREFETCH_BUF_EN
  localparam logic [1:0] Depth = 2'd2;
`else
  localparam logic [1:0] Depth = 2'd1;
`endif
  localparam bit TwoDeep = (Depth == 2'd2);

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e        state_q, state_d;
  logic          imem_req_q, imem_req_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;

  // Storage is always two entries; in the single-entry build only entry 0 is ever used.
  logic [DW-1:0] word_q [2];
  logic [DW-1:0] word_d [2];
  logic [AW-1:0] wpc_q [2];
  logic [AW-1:0] wpc_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;

  logic          push;
  logic          pop;
  logic [1:0]    pc_ps;

  function automatic logic ptr_inc(input logic p);
    return TwoDeep ? ~p : 1'b0;
  endfunction

  assign pop  = (count_q != 2'd0) && bus.ir_ready;
  // An ack is only accepted for a live request that is not being redirected away.
  assign push = (state_q == StReq) && bus.imem_ack && !bus.br_take;

  // Redirect overrides the increment that an accepted ack would otherwise request.
  always_comb begin
    pc_ps = 2'b00;
    if (reset) begin
      pc_ps = 2'b00;
    end else if (bus.br_take) begin
      pc_ps = {1'b1, bus.br_rel};
    end else if (push) begin
      pc_ps = 2'b01;
    end
  end

  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    unique case (state_q)
      StIdle: begin
        if ((count_q < Depth) && !bus.br_take) begin
          state_d     = StReq;
          imem_req_d  = 1'b1;
          imem_addr_d = bus.pc_in;
        end
      end
      StReq: begin
        if (bus.imem_ack) begin
          state_d    = StIdle;
          imem_req_d = 1'b0;
        end else if (bus.br_take) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (bus.imem_ack) begin
          state_d    = StIdle;
          imem_req_d = 1'b0;
        end
      end
      default: begin
        state_d    = StIdle;
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    word_d   = word_q;
    wpc_d    = wpc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      word_d[wr_ptr_q] = bus.imem_data;
      wpc_d[wr_ptr_q]  = imem_addr_q;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
    // Flush on redirect; a pop in the same cycle has already been taken by decode.
    if (bus.br_take) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        word_q[i] <= '0;
        wpc_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      word_q      <= word_d;
      wpc_q       <= wpc_d;
    end
  end

  assign bus.pc_ps     = pc_ps;
  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.ir_out    = word_q[rd_ptr_q];
  assign bus.ir_pc     = wpc_q[rd_ptr_q];
  assign bus.ir_valid  = (count_q != 2'd0);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC register, latency-programmable memory and an in-order
// instruction-stream scoreboard, driven by directed steps followed by random traffic.
module tb_instr_fetch;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  instr_fetch_if #(.AW(AW), .DW(DW)) bus ();

  instr_fetch #(.AW(AW), .DW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] pc_model = 32'd0;
  logic [31:0] pc_prev  = 32'd0;
  logic [31:0] exp_pc   = 32'd0;
  logic [31:0] req_addr = 32'd0;
  bit          outstanding = 1'b0;
  bit          stale = 1'b0;
  int          wait_left = 0;
  int          lat_fixed = 0;
  int          n_deliv = 0;
  int          n_issue = 0;
  bit          prev_hold = 1'b0;
  bit          prev_br = 1'b0;
  logic [31:0] prev_out = 32'd0;
  logic [31:0] prev_pc = 32'd0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance models at posedge.
  task automatic cycle(input bit br, input bit rel, input logic [31:0] tgt, input bit rdy);
    logic       ack;
    logic [1:0] exp_ps;
    logic [1:0] obs_ps;
    bit         xfer;
    bus.br_take  = br;
    bus.br_rel   = rel;
    bus.ir_ready = rdy;
    bus.pc_in    = pc_model;
    ack = 1'b0;
    if (!reset && bus.imem_req === 1'b1) begin
      if (!outstanding) begin
        check("addr_at_issue", bus.imem_addr, pc_prev);
        outstanding = 1'b1;
        req_addr    = bus.imem_addr;
        n_issue++;
        wait_left = (lat_fixed < 0) ? int'($urandom_range(3, 0)) : lat_fixed;
      end else begin
        check("addr_stable", bus.imem_addr, req_addr);
      end
      ack = (wait_left == 0);
    end
    bus.imem_ack  = ack;
    bus.imem_data = ack ? memf(req_addr) : $urandom;

    @(negedge clock);
    if (reset)             exp_ps = 2'b00;
    else if (br)           exp_ps = {1'b1, rel};
    else if (ack && !stale) exp_ps = 2'b01;
    else                   exp_ps = 2'b00;
    obs_ps = bus.pc_ps;
    check("pc_ps", obs_ps, exp_ps);
    if (!reset) begin
      if (prev_br) check("flush_valid", bus.ir_valid, 1'b0);
      if (prev_hold) begin
        check("hold_out", bus.ir_out, prev_out);
        check("hold_pc", bus.ir_pc, prev_pc);
      end
      xfer = (bus.ir_valid === 1'b1) && rdy;
      if (xfer) begin
        check("ir_pc", bus.ir_pc, exp_pc);
        check("ir_out", bus.ir_out, memf(exp_pc));
        exp_pc = exp_pc + 32'd1;
        n_deliv++;
      end
    end
    prev_hold = !reset && (bus.ir_valid === 1'b1) && !rdy && !br;
    prev_out  = bus.ir_out;
    prev_pc   = bus.ir_pc;
    prev_br   = br && !reset;

    @(posedge clock);
    pc_prev = pc_model;
    case (obs_ps)
      2'b01:   pc_model = pc_model + 32'd1;
      2'b10:   pc_model = tgt;
      2'b11:   pc_model = pc_model + tgt;
      default: pc_model = pc_model;
    endcase
    if (reset || ack) begin
      outstanding = 1'b0;
      stale       = 1'b0;
    end else if (outstanding) begin
      wait_left--;
      if (br) stale = 1'b1;
    end
    if (br && !reset) exp_pc = pc_model;
    #1;
  endtask

  initial begin
    bit          found;
    int          base;
    logic [31:0] tgt_pc;
    bus.pc_in     = '0;
    bus.br_take   = 1'b0;
    bus.br_rel    = 1'b0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    bus.ir_ready  = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Reset held for two cycles.
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_valid", bus.ir_valid, 1'b0);
    check("rst_out", bus.ir_out, 32'd0);
    check("rst_irpc", bus.ir_pc, 32'd0);
    check("rst_addr", bus.imem_addr, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("first_req", bus.imem_req, 1'b1);
    check("first_addr", bus.imem_addr, 32'd0);

    // Straight-line fetch with zero-latency memory.
    lat_fixed = 0;
    for (int i = 0; i < 20 && n_deliv < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("straight_deliv", n_deliv >= 3, 1'b1);

    // Three-cycle memory latency.
    lat_fixed = 3;
    base = n_deliv;
    for (int i = 0; i < 24; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("slow_deliv", n_deliv >= base + 3, 1'b1);

    // Decode stall after a redirect to a known-empty state.
    lat_fixed = 0;
    cycle(1'b1, 1'b0, 32'h20, 1'b0);
    base = n_issue;
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
`ifdef PREFETCH_BUF_EN
    check("stall_issues", n_issue - base, 2);
`else
    check("stall_issues", n_issue - base, 1);
`endif
    check("stall_valid", bus.ir_valid, 1'b1);
    check("stall_pc", bus.ir_pc, 32'h20);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);

    // Relative redirect while a slow request is waiting.
    lat_fixed = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.imem_req === 1'b1 && outstanding && wait_left > 0) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'd0, 1'b1);
    end
    check("wait_req_found", found, 1'b1);
    cycle(1'b1, 1'b1, 32'd16, 1'b1);
    tgt_pc = pc_model;
    base = n_issue;
    for (int i = 0; i < 15 && n_issue == base; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("redirect_issue", n_issue - base, 1);
    check("redirect_addr", req_addr, tgt_pc);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);

    // Redirect coincident with an ack.
    lat_fixed = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.imem_req === 1'b1 && !outstanding) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'd0, 1'b1);
    end
    check("ack_req_found", found, 1'b1);
    cycle(1'b1, 1'b1, 32'd5, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);

    // Random traffic.
    lat_fixed = -1;
    base = n_deliv;
    for (int i = 0; i < 400; i++) begin
      bit          rb;
      bit          rr;
      logic [31:0] rt;
      rb = ($urandom_range(99, 0) < 4);
      rr = $urandom_range(1, 0) == 1;
      rt = rr ? 32'($urandom_range(40, 0)) : 32'($urandom_range(200, 0));
      cycle(rb, rr, rt, $urandom_range(9, 0) < 7);
    end
    check("random_deliv", n_deliv > base + 50, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
